// File: rtl/posit_ser_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : posit_ser_pkg                                              |
// | Description : Shared constants, state encoding and the precision clamp   |
// |               used by the posit weight serializer and its input FIFO.    |
// |               No ports (package).                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package posit_ser_pkg;

  localparam int SER_MAX_PREC = 8;  // widest posit word in bits
  localparam int SER_PREC_W   = 4;  // width of the precision field

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Posits narrower than 2 bits carry no regime, so 2 is the floor.
  function automatic int clamp_prec(input int p, input int max_p);
    if (p < 2) begin
      return 2;
    end else if (p > max_p) begin
      return max_p;
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/posit_weight_serializer_fifo2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : posit_fifo2                                                |
// | Description : Two-entry synchronous FIFO with full/empty flags.          |
// |               Push and pop may occur in the same cycle.                  |
// | Ports       : clk, rst (async active-low), push_i, pop_i, din_i,         |
// |               dout_o (head word), full_o, empty_o                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module posit_fifo2
  import posit_ser_pkg::*;
#(
  parameter int W     = SER_MAX_PREC,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         w_do_push;
  logic         w_do_pop;

  assign full_o    = (cnt_q == 2'(DEPTH));
  assign empty_o   = (cnt_q == 2'd0);
  assign dout_o    = mem_q[rd_q];
  // A push into a full FIFO is dropped even if a pop happens in the same
  // cycle; the slot freed by the pop becomes writable one cycle later.
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({w_do_push, w_do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (w_do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= ~wr_q;
      end
      if (w_do_pop) begin
        rd_q <= ~rd_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/posit_weight_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : posit_weight_serializer                                    |
// | Description : Buffers parallel posit (es=0) weight words and streams     |
// |               each one MSB-first, one bit per enabled cycle, to the      |
// |               bit-serial FP x posit multiplier.                          |
// | Ports       : clk, rst (async active-low)                                |
// |               set/precision     - program word width while idle        |
// |               in_valid/in_ready/in_posit - parallel word handshake       |
// |               out_en            - downstream enable (0 freezes stream)   |
// |               w_out/valid_out/last_out - serial bit stream               |
// |               busy              - a word sits in the shift register      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module posit_weight_serializer
  import posit_ser_pkg::*;
#(
  parameter int MAX_PREC   = SER_MAX_PREC,
  parameter int PREC_W     = SER_PREC_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set,
  input  logic [PREC_W-1:0]   precision,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_PREC-1:0] in_posit,
  input  logic                out_en,
  output logic                w_out,
  output logic                valid_out,
  output logic                last_out,
  output logic                busy
);

  state_t              state_q;
  state_t              state_d;
  logic [MAX_PREC-1:0] shift_q;
  logic [MAX_PREC-1:0] shift_d;
  logic [PREC_W-1:0]   cnt_q;
  logic [PREC_W-1:0]   cnt_d;
  logic [PREC_W-1:0]   prec_q;
  logic [PREC_W-1:0]   prec_d;

  logic [MAX_PREC-1:0] w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_last_bit;
  logic [PREC_W-1:0]   w_shamt;

  assign in_ready   = !w_full;
  assign w_push     = in_valid && in_ready;
  assign w_last_bit = (cnt_q == (prec_q - PREC_W'(1)));
  // Left-aligning the word pushes any bits above prec_q out of the register,
  // so the upper bits of in_posit never reach the stream.
  assign w_shamt    = PREC_W'(MAX_PREC) - prec_q;

  posit_fifo2 #(
    .W     (MAX_PREC),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (in_posit),
    .dout_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      prec_q  <= PREC_W'(MAX_PREC);
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      prec_q  <= prec_d;
    end
  end

  // Next-state logic. A load on the last enabled bit of a word lets the next
  // word follow without a bubble cycle.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    prec_d  = prec_q;
    w_pop   = 1'b0;

    if (!w_empty && ((state_q == IDLE) ||
                     ((state_q == SHIFT) && out_en && w_last_bit))) begin
      w_pop   = 1'b1;
      shift_d = w_head << w_shamt;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if ((state_q == SHIFT) && out_en) begin
      if (w_last_bit) begin
        state_d = IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end else begin
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + PREC_W'(1);
      end
    end

    // Precision can only change with nothing in flight, so a word is never
    // split across two widths.
    if (set && (state_q == IDLE) && w_empty) begin
      prec_d = PREC_W'(clamp_prec(int'(precision), MAX_PREC));
    end
  end

  // Outputs depend only on registers plus the downstream enable.
  always_comb begin
    busy      = (state_q == SHIFT);
    w_out     = busy ? shift_q[MAX_PREC-1] : 1'b0;
    valid_out = busy && out_en;
    last_out  = busy && out_en && w_last_bit;
  end

endmodule
`default_nettype wire

// File: tb/tb_posit_weight_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_posit_weight_serializer                                 |
// | Description : Directed self-checking bench for posit_weight_serializer.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_posit_weight_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       set;
  logic [3:0] precision;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_posit;
  logic       out_en;
  logic       w_out;
  logic       valid_out;
  logic       last_out;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0;

  logic bits_q[$];
  logic lasts_q[$];
  int   vc_q[$];

  posit_weight_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .set       (set),
    .precision (precision),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_posit  (in_posit),
    .out_en    (out_en),
    .w_out     (w_out),
    .valid_out (valid_out),
    .last_out  (last_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every valid serial bit, its last flag and the cycle it appeared in.
  always @(negedge clk) begin
    if (valid_out) begin
      bits_q.push_back(w_out);
      lasts_q.push_back(last_out);
      vc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic q[$]);
    logic [31:0] v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    bits_q.delete();
    lasts_q.delete();
    vc_q.delete();
  endtask

  // Present a word; holds it until in_ready was seen, then drops in_valid.
  task automatic push(input logic [7:0] w, input logic do_set, input logic [3:0] p);
    int t = 0;
    set       = do_set;
    precision = p;
    in_valid  = 1'b1;
    in_posit  = w;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) chk("push_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    set      = 1'b0;
  endtask

  task automatic wait_cnt(input int n);
    int t = 0;
    while (bits_q.size() < n && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) chk("wait_bits", bits_q.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    set       = 1'b0;
    precision = 4'd0;
    in_valid  = 1'b0;
    in_posit  = 8'h00;
    out_en    = 1'b1;
    #1;
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_wout",  {31'd0, w_out},     32'd0);
    chk("rst_last",  {31'd0, last_out},  32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // prec 8, 0110_1001
    clear_mon();
    push(8'h69, 1'b1, 4'd8);
    c0 = cyc;
    wait_cnt(8);
    chk("t1_latency", vc_q[0], c0 + 1);
    chk("t1_busy_on_last", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    chk("t1_count", bits_q.size(), 8);
    chk("t1_bits",  pack(bits_q),  32'h69);
    chk("t1_last",  pack(lasts_q), 32'h01);

    // prec 5, upper bits set and ignored
    clear_mon();
    push(8'hF6, 1'b1, 4'd5);
    wait_cnt(5);
    repeat (4) tick();
    chk("t2_count", bits_q.size(), 5);
    chk("t2_bits",  pack(bits_q),  32'h16);
    chk("t2_last",  pack(lasts_q), 32'h01);

    // prec 6, three words back-to-back
    clear_mon();
    push(8'h2C, 1'b1, 4'd6);
    push(8'h13, 1'b0, 4'd6);
    push(8'h38, 1'b0, 4'd6);
    chk("t3_ready_full", {31'd0, in_ready}, 32'd0);
    wait_cnt(18);
    repeat (4) tick();
    chk("t3_count", bits_q.size(), 18);
    chk("t3_bits",  pack(bits_q),  32'h2C4F8);
    chk("t3_last",  pack(lasts_q), 32'h01041);
    chk("t3_span",  vc_q[17] - vc_q[0] + 1, 18);

    // out_en pause after bit 3 of A5
    clear_mon();
    push(8'hA5, 1'b1, 4'd8);
    wait_cnt(3);
    @(posedge clk);
    #1 out_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_pause_valid", {31'd0, valid_out}, 32'd0);
      chk("t4_pause_wout",  {31'd0, w_out},     32'd0);
    end
    @(posedge clk);
    #1 out_en = 1'b1;
    wait_cnt(8);
    repeat (3) tick();
    chk("t4_count", bits_q.size(), 8);
    chk("t4_bits",  pack(bits_q),  32'hA5);
    chk("t4_last",  pack(lasts_q), 32'h01);

    // set while busy is ignored
    clear_mon();
    push(8'hC3, 1'b1, 4'd8);
    tick();
    set       = 1'b1;
    precision = 4'd4;
    tick();
    set = 1'b0;
    wait_cnt(8);
    repeat (3) tick();
    chk("t5_busyset_count", bits_q.size(), 8);
    chk("t5_busyset_bits",  pack(bits_q),  32'hC3);

    // set while idle applies to the word presented with it
    clear_mon();
    push(8'h0B, 1'b1, 4'd4);
    wait_cnt(4);
    repeat (3) tick();
    chk("t5_p4_count", bits_q.size(), 4);
    chk("t5_p4_bits",  pack(bits_q),  32'hB);
    chk("t5_p4_last",  pack(lasts_q), 32'h1);

    // precision 1 clamps to 2
    clear_mon();
    push(8'hF2, 1'b1, 4'd1);
    wait_cnt(2);
    repeat (3) tick();
    chk("t5_clamp_count", bits_q.size(), 2);
    chk("t5_clamp_bits",  pack(bits_q),  32'h2);
    chk("t5_clamp_last",  pack(lasts_q), 32'h1);

    // reset mid-word with two words buffered
    clear_mon();
    push(8'h11, 1'b1, 4'd8);
    push(8'h22, 1'b0, 4'd8);
    push(8'h33, 1'b0, 4'd8);
    wait_cnt(4);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, valid_out}, 32'd0);
    chk("t6_rst_wout",  {31'd0, w_out},     32'd0);
    chk("t6_rst_busy",  {31'd0, busy},      32'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("t6_ready", {31'd0, in_ready}, 32'd1);
    repeat (30) tick();
    chk("t6_no_stale", bits_q.size(), 4);
    chk("t6_idle_busy", {31'd0, busy}, 32'd0);

    // a fresh word after reset streams alone, at the reset precision
    clear_mon();
    push(8'h5A, 1'b0, 4'd0);
    wait_cnt(8);
    repeat (12) tick();
    chk("t6_fresh_count", bits_q.size(), 8);
    chk("t6_fresh_bits",  pack(bits_q),  32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/posit_weight_serializer.md
Name: posit_weight_serializer

Overview:
- Transmit-side partner of the bit-serial FP×posit multiplier.
- Accepts parallel posit weight words (es = 0, up to 8 bits) through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Streams each word MSB-first (sign, regime, mantissa), one bit per cycle, on w_out/valid_out.
- The multiplier's bit counter advances only on valid, so stream pauses are legal; precision is programmed with the same set/precision convention the multiplier uses.

Parameters:
- MAX_PREC, 8, maximum posit width in bits.
- PREC_W, 4, width of the precision field.
- FIFO_DEPTH, 2, input buffer entries (fixed at 2; other values are not supported).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- set  input  1  latch precision; honoured only when idle (FIFO empty and not busy)
- precision  input  PREC_W  posit width for subsequent words
- in_valid  input  1  in_posit valid
- in_ready  output  1  FIFO can accept a word
- in_posit  input  MAX_PREC  posit word, right-aligned in the low `precision` bits
- out_en  input  1  downstream enable; 0 freezes the stream
- w_out  output  1  current serial bit
- valid_out  output  1  w_out is valid this cycle
- last_out  output  1  w_out is the final bit of the word
- busy  output  1  a word is loaded in the shift register

Behaviour:
- Reset (async, rst = 0):
  - FIFO emptied, busy = 0, bit_cnt = 0, shift register = 0, prec_q = MAX_PREC.
  - in_ready = 1 once released; w_out = 0, valid_out = 0, last_out = 0 immediately.
  - Reset mid-word discards the partial word and all buffered words, with no further output.
- Precision:
  - set && !busy && FIFO empty at a rising edge: prec_q <= clamp(precision, 2, MAX_PREC).
  - set otherwise is ignored; prec_q is never changed mid-stream.
- Input handshake:
  - Transfer on in_valid && in_ready; in_ready = !fifo_full.
  - Push and pop in the same cycle are allowed while full: in_ready stays 0 while full, and the pop frees the slot for the next cycle.
- Load:
  - Condition: FIFO not empty and (state IDLE, or last_out && out_en this cycle).
  - Action: pop the head into shift_reg left-aligned (head << (MAX_PREC - prec_q)), bit_cnt <= 0, busy <= 1.
  - Back-to-back words therefore stream with zero bubble cycles.
- State machine IDLE/SHIFT:
  - IDLE -> SHIFT on load.
  - SHIFT, step condition out_en = 1:
    - if bit_cnt < prec_q-1: shift_reg <<= 1, bit_cnt++.
    - if bit_cnt == prec_q-1: reload if the FIFO is not empty, else go to IDLE (busy <= 0).
  - SHIFT with out_en = 0: hold every register.
- Outputs (combinational from registers):
  - w_out = shift_reg[MAX_PREC-1] when busy, else 0.
  - valid_out = busy && out_en.
  - last_out = valid_out && bit_cnt == prec_q-1.
- Latency:
  - A word accepted at edge T into an empty, idle block appears as its first bit after edge T+1 (FIFO write, then load).
  - A word of precision p occupies exactly p valid cycles.
- Width rule: bits of in_posit above prec_q are ignored.
- Simultaneous events:
  - set together with in_valid while idle: the new precision applies to that word.
  - out_en = 0 on a last-bit cycle: no load or pop occurs; last_out = 0 until out_en returns.

Decomposition:
- Package posit_ser_pkg holds:
  - MAX_PREC and PREC_W constants.
  - state typedef {IDLE, SHIFT}.
  - clamp_prec function.
- One natural sub-module: posit_fifo2, a 2-entry synchronous FIFO with async active-low reset and full/empty flags, simultaneous push/pop allowed.

Test Plan:
- prec 8, in_posit 8'b0110_1001, out_en = 1 -> w_out 0,1,1,0,1,0,0,1 on 8 consecutive valid cycles; last_out only on the 8th; busy drops the cycle after.
- prec 5, in_posit 8'bxxx1_0110 -> exactly 5 valid bits 1,0,1,1,0; upper bits ignored; last_out on bit 5.
- prec 6, three words pushed on consecutive cycles -> in_ready drops once FIFO holds 2; 18 contiguous valid_out cycles with no gap; last_out at cycles 6, 12, 18.
- out_en low for 3 cycles after bit 3 of 8'hA5 -> valid_out = 0, w_out holds bit 4 value; stream resumes with remaining bits 0,0,1,0,1 in order.
- set with precision 4 while busy -> ignored, word finishes at 8 bits; set again when idle -> next word 4 bits. precision 1 -> clamped to 2.
- rst asserted at bit 4 of a word with 2 words buffered -> valid_out = 0 immediately; after release in_ready = 1, FIFO empty, no stale bits emitted.
